// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, widths and baud arithmetic for the transmitter and receiver
package uart_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: clearable bit-period counter, bit_tick on the last clock of each bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_tick = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk)
        cnt <= (!rst_n || clr || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with start/ready handshake and one-cycle done pulse
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and stop (11-bit frame).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 1_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              tx_start,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_done
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    uart_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        idx;
    logic              tick;
    logic              tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif
    assign tx_ready = state == IDLE;
    // counter held in IDLE so bit boundaries line up with request acceptance
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == IDLE),
        .bit_tick (tick)
    );
    always_comb begin
        tx_nxt = state != START;
        if (state == DATA) tx_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
        if (state == PARITY) tx_nxt = par;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tx      <= tx_nxt;
            tx_done <= 1'b0;
            case (state)
                IDLE: if (tx_start) begin
                    shreg <= din;
                    state <= START;
`ifdef UART_TX_PARITY_EN
                    par   <= ^din;
`endif
                end
                START: if (tick) begin
                    idx   <= '0;
                    state <= DATA;
                end
                DATA: if (tick) begin
                    shreg <= shreg >> 1;
                    idx   <= idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (idx == 3'd7) state <= PARITY;
`else
                    if (idx == 3'd7) state <= STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) state <= STOP;
`endif
                STOP: if (tick) begin
                    tx_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed frames checked cycle by cycle against an ideal line waveform
module tb_uart_tx;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready, tx, tx_done;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_done  (tx_done)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // ideal frame: start 0, data LSB first, optional even parity, stop 1
    function automatic logic line_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NB == 11 && j == 9) return logic'($countones(b) % 2);
        return 1'b1;
    endfunction
    // entered at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic send(input logic [7:0] b, input bit hold, input bit mid, input logic [7:0] noise);
        din = b;
        tx_start = 1'b1;
        chk("ready_before", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        din = noise;
        tx_start = hold;
        chk("tx_accept_cycle", tx, 1);
        chk("ready_after_accept", tx_ready, 0);
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            tx_start = hold || (mid && k >= 30 && k < 40);
            chk($sformatf("tx %02h k=%0d", b, k), tx, line_bit(b, (k - 1) / CPB));
            chk($sformatf("done %02h k=%0d", b, k), tx_done, k == FL);
            chk($sformatf("ready %02h k=%0d", b, k), tx_ready, k == FL);
        end
    endtask
    task automatic idle(input int n);
        tx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1);
            chk("idle_done", tx_done, 0);
            chk("idle_ready", tx_ready, 1);
        end
    endtask
    initial begin
        logic [7:0] b;
        bit         h;
        tx_start = 1'b1;
        din = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_ready", tx_ready, 1);
            chk("rst_done", tx_done, 0);
        end
        tx_start = 1'b0;
        rst_n = 1'b1;
        idle(3);
        send(8'hA5, 0, 0, 8'h00);
        idle(2);
        send(8'h00, 1, 0, 8'hFF);
        send(8'hFF, 0, 0, 8'h12);
        idle(2);
        send(8'h81, 0, 1, 8'h3C);
        idle(FL + 5);
        din = 8'hC6;
        tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (44) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_done", tx_done, 0);
        rst_n = 1'b1;
        idle(FL + 5);
        send(8'h55, 0, 0, 8'hAA);
        idle(1);
        send(8'h07, 0, 0, 8'h00);
        idle(1);
        send(8'h03, 0, 0, 8'h00);
        idle(1);
        for (int r = 0; r < 12; r++) begin
            b = 8'($urandom);
            h = 1'($urandom);
            send(b, h, 1'($urandom), 8'($urandom));
            if (!h) idle($urandom_range(0, 3));
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
